// File: rtl/mac_pipe.sv
// Two-stage pipelined unsigned multiply-accumulate: stage 1 registers a*b and the
// sample controls, stage 2 forms the mode-0 sum or the saturating running accumulate.
module mac_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             acc_mode,
  input  logic             acc_clear,
  output logic             out_valid,
  output logic [ACC_W-1:0] data_out,
  output logic             sat
);

  localparam int PW = 2*WIDTH;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  logic [PW-1:0]    prod_s;
  logic [PW-1:0]    p1_q;
  logic [WIDTH-1:0] c1_q;
  logic             m1_q;
  logic             clr1_q;
  logic             v1_q;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic             sat_q, sat_d;
  logic             ov_q;

  logic [ACC_W-1:0] acc_base_s;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] mode0_s;

  assign prod_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Stage 1 capture; v1 follows in_valid every edge so gaps propagate unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q   <= {PW{1'b0}};
      c1_q   <= {WIDTH{1'b0}};
      m1_q   <= 1'b0;
      clr1_q <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      p1_q   <= prod_s;
      c1_q   <= c;
      m1_q   <= acc_mode;
      clr1_q <= acc_clear;
      v1_q   <= in_valid;
    end
  end

  // Stage 2 result selection; one guard bit above ACC_W flags accumulate overflow.
  always_comb begin
    acc_base_s = clr1_q ? {ACC_W{1'b0}} : acc_q;
    sum_s      = {1'b0, acc_base_s}
               + {{(ACC_W+1-PW){1'b0}}, p1_q}
               + {{(ACC_W+1-WIDTH){1'b0}}, c1_q};
    mode0_s    = {{(ACC_W-PW){1'b0}}, p1_q} + {{(ACC_W-WIDTH){1'b0}}, c1_q};
    acc_d      = acc_q;
    data_d     = data_q;
    sat_d      = sat_q;
    if (v1_q) begin
      if (m1_q) begin
        if (sum_s[ACC_W]) begin
          acc_d  = ACC_MAX;
          data_d = ACC_MAX;
          sat_d  = 1'b1;
        end else begin
          acc_d  = sum_s[ACC_W-1:0];
          data_d = sum_s[ACC_W-1:0];
          sat_d  = 1'b0;
        end
      end else begin
        data_d = mode0_s;
        sat_d  = 1'b0;
      end
    end else begin
      acc_d  = acc_q;
      data_d = data_q;
      sat_d  = sat_q;
    end
  end

  // Stage 2 registers; outputs are driven straight from these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= {ACC_W{1'b0}};
      data_q <= {ACC_W{1'b0}};
      sat_q  <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      data_q <= data_d;
      sat_q  <= sat_d;
      ov_q   <= v1_q;
    end
  end

  assign out_valid = ov_q;
  assign data_out  = data_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed plus randomized bench for mac_pipe (WIDTH=8, ACC_W=20) against a
// sample-level reference model that computes each result when the sample is accepted.
module tb_mac_pipe;

  localparam int WIDTH = 8;
  localparam int ACC_W = 20;
  localparam longint MAXV = (64'd1 << ACC_W) - 64'd1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a, b, c;
  logic             acc_mode, acc_clear;
  logic             out_valid;
  logic [ACC_W-1:0] data_out;
  logic             sat;

  mac_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .acc_mode(acc_mode), .acc_clear(acc_clear),
    .out_valid(out_valid), .data_out(data_out), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one in-flight slot, visible outputs, running sum.
  logic   s_v;
  longint s_d;
  logic   s_s;
  logic   m_ov;
  longint m_do;
  logic   m_sat;
  longint m_acc;

  task automatic reset_model();
    s_v = 1'b0; s_d = 0; s_s = 1'b0;
    m_ov = 1'b0; m_do = 0; m_sat = 1'b0; m_acc = 0;
  endtask

  task automatic model_accept();
    longint prod, sum;
    prod = longint'(a) * longint'(b);
    if (!acc_mode) begin
      s_d = prod + longint'(c);
      s_s = 1'b0;
    end else begin
      sum = (acc_clear ? 0 : m_acc) + prod + longint'(c);
      if (sum > MAXV) begin
        s_d = MAXV; s_s = 1'b1;
      end else begin
        s_d = sum; s_s = 1'b0;
      end
      m_acc = s_d;
    end
  endtask

  task automatic check_model();
    n_vec++;
    assert (out_valid === m_ov) else begin
      n_err++; $error("FAIL out_valid: got %0b want %0b", out_valid, m_ov);
    end
    n_vec++;
    assert (data_out === ACC_W'(m_do)) else begin
      n_err++; $error("FAIL data_out: got %0d want %0d", data_out, m_do);
    end
    n_vec++;
    assert (sat === m_sat) else begin
      n_err++; $error("FAIL sat: got %0b want %0b", sat, m_sat);
    end
  endtask

  task automatic expect_out(input string tag, input longint d, input logic s);
    n_vec++;
    assert (out_valid === 1'b1 && data_out === ACC_W'(d) && sat === s) else begin
      n_err++;
      $error("FAIL %s: got v=%0b d=%0d s=%0b want v=1 d=%0d s=%0b",
             tag, out_valid, data_out, sat, d, s);
    end
  endtask

  task automatic expect_idle(input string tag);
    n_vec++;
    assert (out_valid === 1'b0) else begin
      n_err++; $error("FAIL %s: got out_valid=%0b want 0", tag, out_valid);
    end
  endtask

  task automatic drive(input logic v, input int ia, input int ib, input int ic,
                       input logic mode, input logic clr);
    in_valid  = v;
    a         = WIDTH'(ia);
    b         = WIDTH'(ib);
    c         = WIDTH'(ic);
    acc_mode  = mode;
    acc_clear = clr;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  // Advance one edge, update the model, then compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      reset_model();
    end else begin
      m_ov = s_v;
      if (s_v) begin
        m_do = s_d; m_sat = s_s;
      end
      s_v = in_valid;
      if (in_valid) model_accept();
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    reset_model();
    rst_n = 1'b0;
    idle();

    // Reset held with live random traffic.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom_range(255), $urandom_range(255), $urandom_range(255),
            1'($urandom_range(1)), 1'($urandom_range(1)));
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick(); tick();
    expect_idle("post_reset_quiet");

    // Mode 0 with maximum operands and a one-cycle input gap.
    drive(1'b1, 255, 255, 255, 1'b0, 1'b0); tick();
    idle(); tick();
    expect_out("m0_max", 65280, 1'b0);
    drive(1'b1, 255, 255, 255, 1'b0, 1'b0); tick();
    expect_idle("m0_gap");
    idle(); tick();
    expect_out("m0_max2", 65280, 1'b0);
    tick();

    // Back-to-back accumulate chain.
    drive(1'b1, 3, 4, 1, 1'b1, 1'b1); tick();
    drive(1'b1, 5, 6, 0, 1'b1, 1'b0); tick();
    expect_out("b2b_0", 13, 1'b0);
    drive(1'b1, 2, 2, 2, 1'b1, 1'b0); tick();
    expect_out("b2b_1", 43, 1'b0);
    idle(); tick();
    expect_out("b2b_2", 49, 1'b0);
    tick();
    expect_idle("b2b_end");

    // Mode 0 interleaved between accumulates leaves the sum alone.
    drive(1'b1, 3, 4, 1, 1'b1, 1'b1); tick();
    drive(1'b1, 2, 3, 4, 1'b0, 1'b0); tick();
    expect_out("il_acc", 13, 1'b0);
    drive(1'b1, 1, 1, 0, 1'b1, 1'b0); tick();
    expect_out("il_m0", 10, 1'b0);
    idle(); tick();
    expect_out("il_acc2", 14, 1'b0);
    tick();

    // Saturation and sticky maximum.
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 255, 255, 255, 1'b1, (i == 0) ? 1'b1 : 1'b0);
      tick();
      if (i == 16) expect_out("sat_16th", 1044480, 1'b0);
      if (i == 17) expect_out("sat_17th", MAXV, 1'b1);
    end
    drive(1'b1, 1, 1, 0, 1'b1, 1'b1); tick();
    expect_out("sat_18th", MAXV, 1'b1);
    idle(); tick();
    expect_out("sat_clear", 1, 1'b0);
    tick();

    // Reset mid-pipeline discards the in-flight sample and the sum.
    drive(1'b1, 7, 7, 7, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    reset_model();
    idle();
    @(negedge clk);
    check_model();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    expect_idle("mid_reset_quiet");
    drive(1'b1, 1, 2, 0, 1'b1, 1'b0); tick();
    idle(); tick();
    expect_out("mid_reset_acc", 2, 1'b0);
    tick();

    // Randomized traffic, clears kept occasional so sums grow between them.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(3) != 0), $urandom_range(255), $urandom_range(255),
            $urandom_range(255), 1'($urandom_range(1)), 1'($urandom_range(15) == 0));
      tick();
    end
    idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
